// File: rtl/fetch_unit.sv
// Instruction fetch stage: one-cycle fetch from a combinational memory into a single IR slot.
// A load happens when the IR slot is empty or is being handed downstream in the same cycle; otherwise fetch stalls.
module fetch_unit #(
   parameter int unsigned RESET_PC   = 0,
   parameter int unsigned ADDR_LIMIT = 256
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] pc,
   input  logic [31:0] instruction,
   output logic [31:0] ir,
   output logic [31:0] ir_pc,
   output logic        ir_valid,
   input  logic        ir_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        halted,
   output logic [31:0] fetch_count
);

   localparam logic [0:0]  FETCH     = 1'b0;
   localparam logic [0:0]  HALT      = 1'b1;
   localparam logic [31:0] LIMIT     = ADDR_LIMIT;
   localparam logic [31:0] RST_PC    = RESET_PC;
   localparam logic [0:0]  RST_STATE = (RST_PC >= LIMIT) ? HALT : FETCH;

   logic [0:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] ir_pc_q, ir_pc_d;
   logic        ir_valid_q, ir_valid_d;
   logic [31:0] fetch_count_q, fetch_count_d;

   logic transfer;
   logic load_ok;

   assign transfer = ir_valid_q & ir_ready;
   assign load_ok  = ~ir_valid_q | transfer;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      ir_d          = ir_q;
      ir_pc_d       = ir_pc_q;
      ir_valid_d    = ir_valid_q;
      fetch_count_d = fetch_count_q;

      // A transfer is counted even when a redirect flushes the slot in the same cycle.
      if (transfer && !(&fetch_count_q)) begin
         fetch_count_d = fetch_count_q + 32'd1;
      end

      if (redirect_valid) begin
         pc_d       = redirect_pc;
         ir_valid_d = 1'b0;
         state_d    = (redirect_pc < LIMIT) ? FETCH : HALT;
      end else if (state_q == FETCH) begin
         if (pc_q >= LIMIT) begin
            state_d = HALT;
            if (transfer) begin
               ir_valid_d = 1'b0;
            end
         end else if (load_ok) begin
            ir_d       = instruction;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = pc_q + 32'd1;
         end
      end else begin
         if (transfer) begin
            ir_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= RST_STATE;
         pc_q          <= RST_PC;
         ir_q          <= '0;
         ir_pc_q       <= '0;
         ir_valid_q    <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         ir_q          <= ir_d;
         ir_pc_q       <= ir_pc_d;
         ir_valid_q    <= ir_valid_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign pc          = pc_q;
   assign ir          = ir_q;
   assign ir_pc       = ir_pc_q;
   assign ir_valid    = ir_valid_q;
   assign fetch_count = fetch_count_q;
   assign halted      = (state_q == HALT) & ~ir_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (256-word and 4-word memories) share stimulus and are checked
// every cycle against a queue-free per-instance behavioural model, plus directed literal checkpoints.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        ir_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   logic [31:0] o_pc [2];
   logic [31:0] o_ir [2];
   logic [31:0] o_irpc [2];
   logic        o_vld [2];
   logic        o_halted [2];
   logic [31:0] o_cnt [2];
   logic [31:0] instr [2];

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   // Memory word k holds 8C000000+k
   assign instr[0] = 32'h8C000000 + o_pc[0];
   assign instr[1] = 32'h8C000000 + o_pc[1];

   fetch_unit #(.RESET_PC(0), .ADDR_LIMIT(256)) dut (
      .clk(clk), .reset(reset), .pc(o_pc[0]), .instruction(instr[0]),
      .ir(o_ir[0]), .ir_pc(o_irpc[0]), .ir_valid(o_vld[0]), .ir_ready(ir_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halted(o_halted[0]), .fetch_count(o_cnt[0])
   );

   fetch_unit #(.RESET_PC(0), .ADDR_LIMIT(4)) dut4 (
      .clk(clk), .reset(reset), .pc(o_pc[1]), .instruction(instr[1]),
      .ir(o_ir[1]), .ir_pc(o_irpc[1]), .ir_valid(o_vld[1]), .ir_ready(ir_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halted(o_halted[1]), .fetch_count(o_cnt[1])
   );

   // Reference model: "running" means fetching is still allowed; the slot holds at most one word.
   logic [31:0] m_pc [2];
   logic [31:0] m_ir [2];
   logic [31:0] m_irpc [2];
   logic        m_vld [2];
   logic        m_run [2];
   logic [31:0] m_cnt [2];
   logic [31:0] m_lim [2];

   initial begin
      m_lim[0] = 32'd256;
      m_lim[1] = 32'd4;
   end

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic handed;
         handed = m_vld[i] && ir_ready;
         if (reset) begin
            m_pc[i]   = 32'd0;
            m_ir[i]   = 32'd0;
            m_irpc[i] = 32'd0;
            m_vld[i]  = 1'b0;
            m_cnt[i]  = 32'd0;
            m_run[i]  = (32'd0 < m_lim[i]);
         end else begin
            if (handed && m_cnt[i] != 32'hFFFFFFFF) m_cnt[i] = m_cnt[i] + 1;
            if (redirect_valid) begin
               m_pc[i]  = redirect_pc;
               m_vld[i] = 1'b0;
               m_run[i] = (redirect_pc < m_lim[i]);
            end else if (!m_run[i] || m_pc[i] >= m_lim[i]) begin
               m_run[i] = 1'b0;
               if (handed) m_vld[i] = 1'b0;
            end else if (!m_vld[i] || handed) begin
               m_ir[i]   = 32'h8C000000 + m_pc[i];
               m_irpc[i] = m_pc[i];
               m_vld[i]  = 1'b1;
               m_pc[i]   = m_pc[i] + 1;
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            check($sformatf("pc[%0d]", i), o_pc[i], m_pc[i]);
            check($sformatf("ir[%0d]", i), o_ir[i], m_ir[i]);
            check($sformatf("ir_pc[%0d]", i), o_irpc[i], m_irpc[i]);
            check($sformatf("ir_valid[%0d]", i), {31'd0, o_vld[i]}, {31'd0, m_vld[i]});
            check($sformatf("halted[%0d]", i), {31'd0, o_halted[i]}, {31'd0, !m_run[i] && !m_vld[i]});
            check($sformatf("fetch_count[%0d]", i), o_cnt[i], m_cnt[i]);
         end
      end
   end

   task automatic edges(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      edges(1);
      reset = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      ir_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      edges(1);
      chk_en = 1'b1;

      // Reset state and streaming
      do_reset();
      @(negedge clk);
      check("rst_pc", o_pc[0], 32'd0);
      check("rst_ir_valid", {31'd0, o_vld[0]}, 32'd0);
      check("rst_halted", {31'd0, o_halted[0]}, 32'd0);
      check("rst_count", o_cnt[0], 32'd0);
      edges(6);
      @(negedge clk);
      check("stream_ir_pc", o_irpc[0], 32'd5);
      check("stream_ir", o_ir[0], 32'h8C000005);
      check("stream_count", o_cnt[0], 32'd5);
      check("eom_halted", {31'd0, o_halted[1]}, 32'd1);
      check("eom_pc", o_pc[1], 32'd4);
      check("eom_count", o_cnt[1], 32'd4);

      // Stall with ir_pc=2 held for three cycles
      do_reset();
      edges(3);
      ir_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         edges(1);
         @(negedge clk);
         check("stall_pc", o_pc[0], 32'd3);
         check("stall_ir_pc", o_irpc[0], 32'd2);
         check("stall_ir_valid", {31'd0, o_vld[0]}, 32'd1);
      end
      ir_ready = 1'b1;
      edges(1);
      @(negedge clk);
      check("unstall_ir_pc3", o_irpc[0], 32'd3);
      edges(1);
      @(negedge clk);
      check("unstall_ir_pc4", o_irpc[0], 32'd4);

      // End of memory with the last word stalled: halted waits for the transfer
      do_reset();
      edges(4);
      ir_ready = 1'b0;
      edges(2);
      @(negedge clk);
      check("eom_stall_halted", {31'd0, o_halted[1]}, 32'd0);
      check("eom_stall_ir_pc", o_irpc[1], 32'd3);
      ir_ready = 1'b1;
      edges(1);
      @(negedge clk);
      check("eom_drain_halted", {31'd0, o_halted[1]}, 32'd1);
      check("eom_drain_count", o_cnt[1], 32'd4);

      // Redirect while ir_pc=8 is pending; the coincident transfer still counts
      do_reset();
      edges(9);
      @(negedge clk);
      check("pre_redir_ir_pc", o_irpc[0], 32'd8);
      redirect_valid = 1'b1;
      redirect_pc    = 32'd17;
      edges(1);
      redirect_valid = 1'b0;
      @(negedge clk);
      check("redir_ir_valid", {31'd0, o_vld[0]}, 32'd0);
      check("redir_pc", o_pc[0], 32'd17);
      check("redir_count", o_cnt[0], 32'd9);
      edges(1);
      @(negedge clk);
      check("redir_ir_pc", o_irpc[0], 32'd17);
      check("redir_ir", o_ir[0], 32'h8C000011);

      // Out-of-range redirect halts; in-range redirect resumes
      redirect_valid = 1'b1;
      redirect_pc    = 32'd300;
      edges(1);
      redirect_valid = 1'b0;
      edges(2);
      @(negedge clk);
      check("halt_halted", {31'd0, o_halted[0]}, 32'd1);
      check("halt_pc", o_pc[0], 32'd300);
      redirect_valid = 1'b1;
      edges(1);
      @(negedge clk);
      check("halt_stays", {31'd0, o_halted[0]}, 32'd1);
      redirect_pc = 32'd1;
      edges(1);
      redirect_valid = 1'b0;
      @(negedge clk);
      check("halt_exit_halted", {31'd0, o_halted[0]}, 32'd0);
      check("halt_exit_pc", o_pc[0], 32'd1);
      edges(1);
      @(negedge clk);
      check("halt_exit_ir_pc", o_irpc[0], 32'd1);
      check("halt_exit_ir_valid", {31'd0, o_vld[0]}, 32'd1);

      // Reset mid-stall overrides redirect and ready
      do_reset();
      edges(8);
      ir_ready = 1'b0;
      edges(1);
      @(negedge clk);
      check("pre_rst_count", o_cnt[0], 32'd7);
      check("pre_rst_ir_valid", {31'd0, o_vld[0]}, 32'd1);
      reset          = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'd50;
      ir_ready       = 1'b1;
      edges(1);
      reset          = 1'b0;
      redirect_valid = 1'b0;
      @(negedge clk);
      check("mid_rst_pc", o_pc[0], 32'd0);
      check("mid_rst_ir_valid", {31'd0, o_vld[0]}, 32'd0);
      check("mid_rst_count", o_cnt[0], 32'd0);
      check("mid_rst_halted", {31'd0, o_halted[0]}, 32'd0);

      // Randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         reset          = ($urandom_range(0, 199) == 0);
         ir_ready       = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc    = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 6))
                                                      : 32'($urandom_range(0, 320));
         edges(1);
      end
      reset          = 1'b0;
      redirect_valid = 1'b0;
      edges(2);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 0, giving the word index loaded into pc on reset.
REQ-002 The block SHALL have parameter ADDR_LIMIT, default 256, giving the instruction-memory depth in words; valid indices are 0..ADDR_LIMIT-1.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port pc, output, 32, word index driven to instruction memory.
REQ-006 The block SHALL have port instruction, input, 32, combinational memory read data for pc, valid in the same cycle.
REQ-007 The block SHALL have port ir, output, 32, latched instruction presented downstream.
REQ-008 The block SHALL have port ir_pc, output, 32, word index from which ir was fetched.
REQ-009 The block SHALL have port ir_valid, output, 1, ir/ir_pc hold an unconsumed instruction.
REQ-010 The block SHALL have port ir_ready, input, 1, downstream accepts ir this cycle.
REQ-011 The block SHALL have port redirect_valid, input, 1, branch/jump taken: resteer fetch.
REQ-012 The block SHALL have port redirect_pc, input, 32, target word index for redirect.
REQ-013 The block SHALL have port halted, output, 1, fetch stopped and no instruction pending.
REQ-014 The block SHALL have port fetch_count, output, 32, number of instructions handed downstream.

Function
REQ-015 FSM states SHALL be FETCH and HALT only; the state register SHALL be encoded explicitly.
REQ-016 Transfer SHALL occur on a cycle with ir_valid=1 and ir_ready=1; load_ok SHALL be ir_valid=0 or transfer.
REQ-017 In FETCH with redirect_valid=0, pc<ADDR_LIMIT and load_ok: at the edge ir<=instruction, ir_pc<=pc, ir_valid<=1, pc<=pc+1 (one-cycle fetch latency).
REQ-018 In FETCH with load_ok=0 (stall), pc, ir, ir_pc and ir_valid SHALL hold.
REQ-019 Transfer without a simultaneous load SHALL clear ir_valid at the edge.
REQ-020 redirect_valid=1 SHALL take priority over load and stall in any state: pc<=redirect_pc, ir_valid<=0 (flush), no memory read latched; a coincident transfer SHALL still count.
REQ-021 Redirect with redirect_pc<ADDR_LIMIT SHALL place the FSM in FETCH; with redirect_pc>=ADDR_LIMIT, in HALT.
REQ-022 In FETCH with pc>=ADDR_LIMIT and no redirect, the FSM SHALL move to HALT without latching; a pending ir SHALL remain until transferred.
REQ-023 In HALT, pc SHALL hold and no load SHALL occur; only reset or an in-range redirect SHALL leave HALT.
REQ-024 halted SHALL be 1 exactly when the state is HALT and ir_valid=0 (registered-state decode, no input dependency).
REQ-025 fetch_count SHALL increment by 1 on each transfer and saturate at 32'hFFFFFFFF.
REQ-026 pc arithmetic SHALL be 32-bit unsigned; pc+1 from 32'hFFFFFFFF is never reached since pc>=ADDR_LIMIT halts first.

Reset
REQ-027 On reset=1 at an edge: pc<=RESET_PC, ir<=0, ir_pc<=0, ir_valid<=0, fetch_count<=0, state<=FETCH (HALT if RESET_PC>=ADDR_LIMIT).
REQ-028 Reset SHALL override redirect_valid, ir_ready and any in-progress state, including mid-stall and HALT.
REQ-029 In the first cycle after reset release, pc=RESET_PC and the first load occurs at the next edge.

Verification
REQ-030 Streaming: memory word k = 32'h8C000000+k, ir_ready=1 -> ir_pc 0,1,2,... on consecutive cycles, ir matches, fetch_count=5 after 5 transfers.
REQ-031 Stall: ir_ready=0 for 3 cycles with ir_pc=2 -> pc=3, ir_pc=2, ir_valid=1 held; after ir_ready=1, ir_pc 3 then 4.
REQ-032 Redirect: redirect_valid=1, redirect_pc=17 while ir_pc=8 valid -> next cycle ir_valid=0, pc=17; following cycle ir_pc=17.
REQ-033 End of memory: ADDR_LIMIT=4, ir_ready=1 -> ir_pc 0..3 delivered, then halted=1, pc=4, fetch_count=4; with ir_ready=0 at ir_pc=3, halted stays 0 until transfer.
REQ-034 Halt exit: in HALT, redirect_pc=300 (ADDR_LIMIT=256) -> stays HALT; redirect_pc=1 -> FETCH, ir_pc=1 next load.
REQ-035 Reset mid-stall: ir_valid=1, ir_ready=0, fetch_count=7, reset=1 one cycle -> pc=0, ir_valid=0, fetch_count=0, halted=0.
